trng_fifo_periph: RTL and testbench
===================================

TRNG_FIFO_PERIPH -- requirements
Module: trng_fifo_periph

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set bits per random word (legal 8..32; words zero-extended to 32 on read).
REQ-002 Parameter DEPTH, default 4, SHALL set FIFO depth in words (power of two, 2..16).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 ent_bit  input  1  SHALL carry one raw entropy bit, sampled when ent_valid is high.
REQ-006 ent_valid  input  1  SHALL qualify ent_bit for one clk cycle.
REQ-007 address  input  6  SHALL select the register within the peripheral space.
REQ-008 data_in  input  32  SHALL carry write data; the low 8, 16 or 32 bits are valid per data_write_n.
REQ-009 data_write_n  input  2  SHALL encode 11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit write.
REQ-010 data_read_n  input  2  SHALL encode 11 = none, 00/01/10 = 8/16/32-bit read.
REQ-011 data_out  output  32  SHALL return the addressed register combinationally.
REQ-012 data_ready  output  1  SHALL be constant 1.
REQ-013 user_interrupt  output  1  SHALL be the level-sensitive FIFO-threshold interrupt.

Function
REQ-014 Register map: 0x0 CTRL (rw), 0x1 STATUS (ro), 0x2 DATA (ro, pop on read), 0x3 INFO (ro); all other addresses SHALL read 0 and ignore writes.
REQ-015 CTRL fields: [0] EN, [1] FLUSH, [2] IRQ_EN, [12:8] THRESH; other bits SHALL read 0.
REQ-016 CTRL writes SHALL honour byte lanes: [7:0] on any write size, [15:8] on 16- and 32-bit writes.
REQ-017 FLUSH SHALL self-clear one cycle after being written, and SHALL read 0.
REQ-018 STATUS fields: [4:0] LEVEL, [8] EMPTY, [9] FULL, [10] OVERFLOW (sticky), [12:11] collector state.
REQ-019 INFO SHALL read {16'(DEPTH), 16'(WORD_W)}.
REQ-020 Collector states SHALL be OFF, COLLECT and PUSH: OFF→COLLECT when EN=1; COLLECT→PUSH when bit count reaches WORD_W; PUSH→COLLECT after 1 cycle; any→OFF when EN=0.
REQ-021 In COLLECT, each accepted bit SHALL shift into the LSB of a WORD_W shift register and increment the count.
REQ-022 ent_valid SHALL be ignored in OFF and in PUSH.
REQ-023 Entering OFF SHALL zero the shift register and count, and SHALL retain FIFO contents.
REQ-024 In PUSH, the word SHALL be written to the FIFO if it is not full; if full, the word SHALL be dropped and OVERFLOW set.
REQ-025 A DATA read SHALL pop exactly one word, on the first cycle of a read strobe (data_read_n != 11 and address 0x2 now, not the previous cycle).
REQ-026 A DATA read SHALL return the head word combinationally in that same cycle.
REQ-027 A DATA read when EMPTY SHALL return 0 and SHALL NOT change state.
REQ-028 A push and a pop in the same cycle SHALL both occur, with LEVEL unchanged (including at FULL).
REQ-029 Pointers SHALL wrap modulo DEPTH; LEVEL SHALL range 0..DEPTH.
REQ-030 FLUSH SHALL clear the FIFO, the collector and OVERFLOW in the next cycle and SHALL take priority over a simultaneous push or pop.
REQ-031 Any write to STATUS SHALL clear OVERFLOW.
REQ-032 user_interrupt SHALL equal IRQ_EN & (THRESH != 0) & (LEVEL >= THRESH).

Reset
REQ-033 rst SHALL asynchronously force CTRL=0, LEVEL=0, both pointers=0, OVERFLOW=0, collector state OFF, shift register=0, count=0 and the read-edge flag=0.
REQ-034 During reset, user_interrupt SHALL be 0 and data_out SHALL reflect the reset register values.
REQ-035 Reset asserted mid-word or mid-read SHALL discard all partial state, with no pop or push completing.

Configuration
REQ-036 With TRNG_VN_DEBIAS_EN defined, accepted bits SHALL pass a von Neumann stage before the collector: pairs 01→0 and 10→1; pairs 00 and 11 are discarded.
REQ-037 The debias pair flag SHALL clear on reset, on FLUSH and on entering OFF.
REQ-038 Without TRNG_VN_DEBIAS_EN, raw bits SHALL feed the collector directly, with no debias logic present.

Structure
REQ-039 A shared package SHALL hold the register address constants, CTRL/STATUS bit-index constants and the collector-state enum.
REQ-040 The FIFO SHALL be a sub-module, trng_word_fifo (parameters WORD_W, DEPTH; push/pop/flush, full/empty/level).

Verification
REQ-041 WORD_W=8, EN=1, bits 1,0,1,1,0,0,1,0 → DATA read = 0x000000B2, LEVEL 1→0.
REQ-042 DEPTH=4, 5 words collected without reads → FULL=1, LEVEL=4, OVERFLOW=1; 4 reads return words 1..4 in order; a 5th read returns 0 with EMPTY=1.
REQ-043 THRESH=2, IRQ_EN=1 → user_interrupt rises in the cycle after the 2nd push and falls in the cycle after the pop that leaves LEVEL=1.
REQ-044 FULL FIFO, DATA read coincident with PUSH → LEVEL stays 4 and OVERFLOW stays 0.
REQ-045 With TRNG_VN_DEBIAS_EN, WORD_W=8, stream 00,01,11,10 repeated → word 0x55 after 16 pairs.
REQ-046 rst pulsed while count=5 and LEVEL=2 → all STATUS fields return to reset values; the next word needs WORD_W fresh bits.

Source files
------------

// File: rtl/trng_fifo_periph_pkg.sv
// trng_fifo_periph_pkg: shared constants for the TRNG FIFO peripheral.
// Holds the register map, CTRL/STATUS bit positions, bus transfer-size
// codes and the entropy collector state enum.
package trng_fifo_periph_pkg;

  // Register addresses
  localparam logic [5:0] ADDR_CTRL   = 6'h0;
  localparam logic [5:0] ADDR_STATUS = 6'h1;
  localparam logic [5:0] ADDR_DATA   = 6'h2;
  localparam logic [5:0] ADDR_INFO   = 6'h3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_FLUSH      = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_THRESH_LSB = 8;
  localparam int unsigned CTRL_THRESH_MSB = 12;

  // STATUS bit positions
  localparam int unsigned STAT_LEVEL_LSB = 0;
  localparam int unsigned STAT_LEVEL_MSB = 4;
  localparam int unsigned STAT_EMPTY     = 8;
  localparam int unsigned STAT_FULL      = 9;
  localparam int unsigned STAT_OVERFLOW  = 10;
  localparam int unsigned STAT_STATE_LSB = 11;
  localparam int unsigned STAT_STATE_MSB = 12;

  // FIFO level field width (covers DEPTH up to 16)
  localparam int unsigned LEVEL_W = 5;

  // data_write_n / data_read_n encodings
  localparam logic [1:0] XFER_8    = 2'b00;
  localparam logic [1:0] XFER_16   = 2'b01;
  localparam logic [1:0] XFER_32   = 2'b10;
  localparam logic [1:0] XFER_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUSH    = 2'd2
  } coll_state_e;

endpackage

// File: rtl/trng_fifo_if.sv
// trng_fifo_if: register bus, entropy input and interrupt of the TRNG peripheral.
// master drives ent_bit/ent_valid/address/data_in/data_write_n/data_read_n;
// slave drives data_out/data_ready/user_interrupt.
interface trng_fifo_if;
  logic        ent_bit;
  logic        ent_valid;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output ent_bit, ent_valid, address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt
  );

  modport slave (
    input  ent_bit, ent_valid, address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt
  );
endinterface

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: DEPTH-entry word FIFO with flush, show-ahead head output.
// Ports: clk, rst (async, active-high), push, pop, flush (flush wins),
//        wdata, rdata_c (combinational head word), full, empty, level.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trng_word_fifo
  import trng_fifo_periph_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [WORD_W-1:0]  wdata,
  output logic [WORD_W-1:0]  rdata_c,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               push_ok;
  logic               pop_ok;
  logic [LEVEL_W-1:0] level_nxt;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata_c = mem[rptr];

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LEVEL_W'(1);
    end else if (!push_ok && pop_ok) begin
      level_nxt = level - LEVEL_W'(1);
    end
  end

  // Pointers and flags; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LEVEL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// File: rtl/trng_fifo_periph.sv
// trng_fifo_periph: entropy collector feeding a word FIFO behind a small register map.
// Ports: clk, rst (async, active-high), bus (trng_fifo_if.slave: entropy input,
//        register read/write, combinational data_out, data_ready, user_interrupt).
// Registers: 0x0 CTRL, 0x1 STATUS, 0x2 DATA (pop on read), 0x3 INFO.
// Build option: define TRNG_VN_DEBIAS_EN to insert a von Neumann debiaser
// between the entropy input and the collector.
module trng_fifo_periph
  import trng_fifo_periph_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  trng_fifo_if.slave bus
);

  localparam int unsigned CW = $clog2(WORD_W + 1);

  coll_state_e        state;
  coll_state_e        state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [CW-1:0]      count;
  logic               en;
  logic               irq_en;
  logic               flush_q;
  logic [4:0]         thresh;
  logic               overflow;
  logic               rd_q;

  logic               wr_any_c;
  logic               wr_ctrl_c;
  logic               wr_status_c;
  logic               lane_hi_c;
  logic               rd_data_c;
  logic               pop_c;
  logic               push_c;
  logic               bit_valid_c;
  logic               bit_val_c;
  logic [31:0]        rd_mux_c;

  logic [WORD_W-1:0]  fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;

  logic               unused_bits;
  assign unused_bits = ^{bus.data_in[31:13], bus.data_in[7:3]};

  // Bus decode
  assign wr_any_c    = (bus.data_write_n != XFER_NONE);
  assign wr_ctrl_c   = wr_any_c && (bus.address == ADDR_CTRL);
  assign wr_status_c = wr_any_c && (bus.address == ADDR_STATUS);
  assign rd_data_c   = (bus.data_read_n != XFER_NONE) && (bus.address == ADDR_DATA);
  // Pop only on the first cycle of a DATA read strobe
  assign pop_c       = rd_data_c && !rd_q && !fifo_empty;

  // Byte lane [15:8] is written by 16- and 32-bit transfers only
  always_comb begin
    lane_hi_c = 1'b0;
    case (bus.data_write_n)
      XFER_8:           lane_hi_c = 1'b0;
      XFER_16, XFER_32: lane_hi_c = 1'b1;
      default:          lane_hi_c = 1'b0;
    endcase
  end

  // CTRL register; FLUSH is a one-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      flush_q <= 1'b0;
      thresh  <= '0;
    end else begin
      flush_q <= 1'b0;
      if (wr_ctrl_c) begin
        en      <= bus.data_in[CTRL_EN];
        irq_en  <= bus.data_in[CTRL_IRQ_EN];
        flush_q <= bus.data_in[CTRL_FLUSH];
        if (lane_hi_c) begin
          thresh <= bus.data_in[CTRL_THRESH_MSB:CTRL_THRESH_LSB];
        end
      end
    end
  end

  // Read-strobe edge flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= 1'b0;
    else     rd_q <= rd_data_c;
  end

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_q;
  logic first_q;
  logic raw_take_c;

  assign raw_take_c  = bus.ent_valid && (state == ST_COLLECT);
  // Unequal pair emits its first bit: 01 -> 0, 10 -> 1
  assign bit_valid_c = raw_take_c && pair_q && (first_q != bus.ent_bit);
  assign bit_val_c   = first_q;

  // Pair tracking for the debiaser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else if (flush_q || (state_nxt == ST_OFF)) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else if (raw_take_c) begin
      if (!pair_q) begin
        first_q <= bus.ent_bit;
        pair_q  <= 1'b1;
      end else begin
        pair_q  <= 1'b0;
      end
    end
  end
`else
  assign bit_valid_c = bus.ent_valid && (state == ST_COLLECT);
  assign bit_val_c   = bus.ent_bit;
`endif

  // Collector state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_OFF;
    else     state <= state_nxt;
  end

  // Collector next state and push strobe; FLUSH restarts, EN=0 overrides all
  always_comb begin
    state_nxt = state;
    push_c    = 1'b0;
    case (state)
      ST_OFF: begin
        if (en) state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (bit_valid_c && (count == CW'(WORD_W - 1))) state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        push_c    = 1'b1;
        state_nxt = ST_COLLECT;
      end
      default: state_nxt = ST_OFF;
    endcase
    if (flush_q) state_nxt = ST_COLLECT;
    if (!en)     state_nxt = ST_OFF;
  end

  // Shift register and bit count; the word stays stable through PUSH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
    end else if (flush_q || (state_nxt == ST_OFF)) begin
      shreg <= '0;
      count <= '0;
    end else if ((state == ST_COLLECT) && bit_valid_c) begin
      shreg <= {shreg[WORD_W-2:0], bit_val_c};
      count <= (count == CW'(WORD_W - 1)) ? '0 : count + CW'(1);
    end
  end

  // Sticky overflow: a word dropped because the FIFO was full with no pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (flush_q || wr_status_c) begin
      overflow <= 1'b0;
    end else if (push_c && fifo_full && !pop_c) begin
      overflow <= 1'b1;
    end
  end

  trng_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (flush_q),
    .wdata   (shreg),
    .rdata_c (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Register read mux
  always_comb begin
    rd_mux_c = '0;
    case (bus.address)
      ADDR_CTRL: begin
        rd_mux_c[CTRL_EN]                          = en;
        rd_mux_c[CTRL_IRQ_EN]                      = irq_en;
        rd_mux_c[CTRL_THRESH_MSB:CTRL_THRESH_LSB]  = thresh;
      end
      ADDR_STATUS: begin
        rd_mux_c[STAT_LEVEL_MSB:STAT_LEVEL_LSB]    = fifo_level;
        rd_mux_c[STAT_EMPTY]                       = fifo_empty;
        rd_mux_c[STAT_FULL]                        = fifo_full;
        rd_mux_c[STAT_OVERFLOW]                    = overflow;
        rd_mux_c[STAT_STATE_MSB:STAT_STATE_LSB]    = state;
      end
      ADDR_DATA: begin
        if (!fifo_empty) rd_mux_c = 32'(fifo_rdata);
      end
      ADDR_INFO: begin
        rd_mux_c = {16'(DEPTH), 16'(WORD_W)};
      end
      default: rd_mux_c = '0;
    endcase
  end

  assign bus.data_out       = rd_mux_c;
  assign bus.data_ready     = 1'b1;
  assign bus.user_interrupt = irq_en && (thresh != '0) && (fifo_level >= thresh);

endmodule

// File: tb/tb_trng_fifo_periph.sv
// tb_trng_fifo_periph: directed self-checking bench for trng_fifo_periph
// (WORD_W=8, DEPTH=4). Works with or without TRNG_VN_DEBIAS_EN: word bits
// are sent as 01/10 pairs when the debiaser is built in.
module tb_trng_fifo_periph;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] rd;

  trng_fifo_if bus_if ();

  trng_fifo_periph #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [5:0] addr, output logic [31:0] val);
    bus_if.address     = addr;
    bus_if.data_read_n = 2'b10;
    #1;
    val = bus_if.data_out;
    bus_if.data_read_n = 2'b11;
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] wn);
    bus_if.address      = addr;
    bus_if.data_in      = data;
    bus_if.data_write_n = wn;
    tick();
    bus_if.data_write_n = 2'b11;
  endtask

  // DATA read: sample head, pop at the edge, then drop the strobe for a cycle
  task automatic pop_read(output logic [31:0] val);
    bus_if.address     = 6'h2;
    bus_if.data_read_n = 2'b10;
    #1;
    val = bus_if.data_out;
    tick();
    bus_if.data_read_n = 2'b11;
    tick();
  endtask

  task automatic raw_bit(input logic b);
    bus_if.ent_bit   = b;
    bus_if.ent_valid = 1'b1;
    tick();
    bus_if.ent_valid = 1'b0;
  endtask

  task automatic enc_bit(input logic b);
`ifdef TRNG_VN_DEBIAS_EN
    raw_bit(b);
    raw_bit(!b);
`else
    raw_bit(b);
`endif
  endtask

  // MSB first, so the first bit ends up in the word MSB
  task automatic send_bits(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) enc_bit(w[i]);
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w);
    tick();
  endtask

  initial begin
    bus_if.ent_bit      = 1'b0;
    bus_if.ent_valid    = 1'b0;
    bus_if.address      = 6'h0;
    bus_if.data_in      = 32'h0;
    bus_if.data_write_n = 2'b11;
    bus_if.data_read_n  = 2'b11;

    // Reset values
    tick(); tick();
    reg_read(6'h1, rd); chk("reset_status", rd, 32'h0000_0100);
    reg_read(6'h0, rd); chk("reset_ctrl",   rd, 32'h0000_0000);
    chk("reset_irq",   32'(bus_if.user_interrupt), 32'd0);
    chk("data_ready",  32'(bus_if.data_ready),     32'd1);
    reg_read(6'h3, rd); chk("info", rd, 32'h0004_0008);
    rst = 1'b0;
    tick();

    // Enable and collect 0xB2
    bus_write(6'h0, 32'h0000_0001, 2'b00);
    reg_read(6'h0, rd); chk("ctrl_en", rd, 32'h0000_0001);
    tick();
    reg_read(6'h1, rd); chk("status_collect", rd, 32'h0000_0900);
    send_word(8'hB2);
    reg_read(6'h1, rd); chk("status_level1", rd, 32'h0000_0801);
    pop_read(rd);       chk("data_b2", rd, 32'h0000_00B2);
    reg_read(6'h1, rd); chk("status_level0", rd, 32'h0000_0900);

    // Read while empty
    pop_read(rd);       chk("empty_read", rd, 32'h0);
    reg_read(6'h1, rd); chk("empty_status", rd, 32'h0000_0900);

    // Unmapped address
    bus_write(6'h05, 32'hFFFF_FFFF, 2'b10);
    reg_read(6'h05, rd); chk("unmapped", rd, 32'h0);

    // Threshold interrupt
    bus_write(6'h0, 32'h0000_0205, 2'b10);
    reg_read(6'h0, rd); chk("ctrl_thresh", rd, 32'h0000_0205);
    send_word(8'h11);
    chk("irq_level1", 32'(bus_if.user_interrupt), 32'd0);
    send_bits(8'h22);
    chk("irq_in_push", 32'(bus_if.user_interrupt), 32'd0);
    tick();
    chk("irq_rise", 32'(bus_if.user_interrupt), 32'd1);
    bus_if.address     = 6'h2;
    bus_if.data_read_n = 2'b10;
    #1;
    chk("irq_pop_data", bus_if.data_out, 32'h0000_0011);
    chk("irq_before_pop", 32'(bus_if.user_interrupt), 32'd1);
    tick();
    bus_if.data_read_n = 2'b11;
    chk("irq_fall", 32'(bus_if.user_interrupt), 32'd0);
    tick();
    pop_read(rd); chk("data_22", rd, 32'h0000_0022);

    // Byte lanes: 8-bit write keeps THRESH
    bus_write(6'h0, 32'h0000_1F01, 2'b00);
    reg_read(6'h0, rd); chk("ctrl_lane8", rd, 32'h0000_0201);

    // Overflow with DEPTH=4
    for (int i = 1; i <= 5; i++) send_word(8'(i));
    reg_read(6'h1, rd); chk("status_full_ovf", rd, 32'h0000_0E04);
    for (int i = 1; i <= 4; i++) begin
      pop_read(rd); chk($sformatf("ovf_data%0d", i), rd, 32'(i));
    end
    pop_read(rd);       chk("ovf_data5", rd, 32'h0);
    reg_read(6'h1, rd); chk("status_empty_ovf", rd, 32'h0000_0D00);
    bus_write(6'h1, 32'h0, 2'b10);
    reg_read(6'h1, rd); chk("ovf_clear", rd, 32'h0000_0900);

    // Push and pop together while full
    for (int i = 6; i <= 9; i++) send_word(8'(i));
    reg_read(6'h1, rd); chk("status_full", rd, 32'h0000_0A04);
    send_bits(8'h0A);
    bus_if.address     = 6'h2;
    bus_if.data_read_n = 2'b10;
    #1;
    chk("coinc_data", bus_if.data_out, 32'h0000_0006);
    tick();
    bus_if.data_read_n = 2'b11;
    tick();
    reg_read(6'h1, rd); chk("coinc_status", rd, 32'h0000_0A04);
    pop_read(rd); chk("coinc_d7", rd, 32'h07);
    pop_read(rd); chk("coinc_d8", rd, 32'h08);
    pop_read(rd); chk("coinc_d9", rd, 32'h09);
    pop_read(rd); chk("coinc_d10", rd, 32'h0A);

    // FLUSH clears FIFO and reads back 0
    send_word(8'h33);
    reg_read(6'h1, rd); chk("pre_flush", rd, 32'h0000_0801);
    bus_write(6'h0, 32'h0000_0003, 2'b00);
    reg_read(6'h0, rd); chk("flush_reads0", rd, 32'h0000_0201);
    tick();
    reg_read(6'h1, rd); chk("post_flush", rd, 32'h0000_0900);

    // Reset mid-word with data queued
    send_word(8'h44);
    send_word(8'h55);
    for (int i = 0; i < 5; i++) enc_bit(1'(i & 1));
    reg_read(6'h1, rd); chk("pre_rst", rd, 32'h0000_0802);
    rst = 1'b1;
    #1;
    reg_read(6'h1, rd); chk("rst_status", rd, 32'h0000_0100);
    reg_read(6'h0, rd); chk("rst_ctrl", rd, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    reg_read(6'h1, rd); chk("post_rst_status", rd, 32'h0000_0100);
    bus_write(6'h0, 32'h0000_0001, 2'b00);
    tick();
    send_word(8'hC3);
    reg_read(6'h1, rd); chk("fresh_level", rd, 32'h0000_0801);
    pop_read(rd);       chk("fresh_word", rd, 32'h0000_00C3);

`ifdef TRNG_VN_DEBIAS_EN
    // Raw stream 00,01,11,10 repeated: unequal pairs give 0,1
    for (int r = 0; r < 4; r++) begin
      raw_bit(1'b0); raw_bit(1'b0);
      raw_bit(1'b0); raw_bit(1'b1);
      raw_bit(1'b1); raw_bit(1'b1);
      raw_bit(1'b1); raw_bit(1'b0);
    end
    tick();
    pop_read(rd); chk("vn_word", rd, 32'h0000_0055);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
